control_unit: RTL and testbench

Hardwired Moore sequencer for the Mini SRC datapath. Each instruction takes a fetch phase T0–T2 and an execute phase T3–T7. In every cycle the block drives the full set of datapath control strobes, decoded from the current state and the opcode held in IR. It sits directly upstream of the datapath: it consumes IR and the branch condition flag, and produces every bus, register, ALU and memory enable.

---
 rtl/cpu_pkg.sv | 71 +++++++
 rtl/cu_class_decode.sv | 31 +++
 rtl/control_unit.sv | 179 +++++++++++++++++
 tb/tb_control_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the Mini SRC control path: opcodes, sequencer states
// and the one-hot instruction class produced by cu_class_decode.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ST_RESET = 4'd0;
    localparam logic [3:0] ST_T0    = 4'd1;
    localparam logic [3:0] ST_T1    = 4'd2;
    localparam logic [3:0] ST_T2    = 4'd3;
    localparam logic [3:0] ST_T3    = 4'd4;
    localparam logic [3:0] ST_T4    = 4'd5;
    localparam logic [3:0] ST_T5    = 4'd6;
    localparam logic [3:0] ST_T6    = 4'd7;
    localparam logic [3:0] ST_T7    = 4'd8;
    localparam logic [3:0] ST_HALT  = 4'd9;

    typedef enum logic [3:0] {
        RESET = ST_RESET,
        T0    = ST_T0,
        T1    = ST_T1,
        T2    = ST_T2,
        T3    = ST_T3,
        T4    = ST_T4,
        T5    = ST_T5,
        T6    = ST_T6,
        T7    = ST_T7,
        HALT  = ST_HALT
    } state_t;

    typedef struct packed {
        logic alu;
        logic imm;
        logic unary;
        logic ld;
        logic ldi;
        logic st;
        logic br;
        logic jr;
        logic jal;
        logic portIn;
        logic portOut;
        logic nop;
        logic halt;
        logic illegal;
    } opClass_t;

endpackage

// File: rtl/cu_class_decode.sv
// Maps an opcode onto exactly one instruction class; anything not listed,
// including the reserved mul/div/mfhi/mflo slots, is illegal.
module cu_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output opClass_t   opClass
);

    always_comb begin
        opClass = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   opClass.alu     = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:          opClass.imm     = 1'b1;
            OP_NEG, OP_NOT:                    opClass.unary   = 1'b1;
            OP_LD:                             opClass.ld      = 1'b1;
            OP_LDI:                            opClass.ldi     = 1'b1;
            OP_ST:                             opClass.st      = 1'b1;
            OP_BR:                             opClass.br      = 1'b1;
            OP_JR:                             opClass.jr      = 1'b1;
            OP_JAL:                            opClass.jal     = 1'b1;
            OP_IN:                             opClass.portIn  = 1'b1;
            OP_OUT:                            opClass.portOut = 1'b1;
            OP_NOP:                            opClass.nop     = 1'b1;
            OP_HALT:                           opClass.halt    = 1'b1;
            default:                           opClass.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for Mini SRC: fetch in T0-T2, execute in T3-T7,
// with every datapath strobe decoded from the state and the live opcode.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        conOut,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        read,
    output logic        write,
    output logic        RAMenable,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CSignout,
    output logic        Yin,
    output logic        conin,
    output logic        ZMuxEnbale,
    output logic        ZSelect,
    output logic        ZMuxOut,
    output logic        ZLOin,
    output logic        ZLOout,
    output logic        OutPortenable,
    output logic        PortInout,
    output logic        R15inC,
    output logic [4:0]  aluControl,
    output logic        run,
    output logic        illegal
);

    state_t   state;
    state_t   stateNext;
    opClass_t liveClass;
    opClass_t opClassQ;
    logic     illegalQ;
    logic [31:0] unusedBits;

    cu_class_decode uDecode (
        .opcode  (ir[31:27]),
        .opClass (liveClass)
    );

    // Sequencing uses the class captured as IR loads, so later ir wiggles
    // cannot change the length of the instruction in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= RESET;
            opClassQ <= '0;
            illegalQ <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == T2)
                opClassQ <= liveClass;
            if (state == T3 && opClassQ.illegal)
                illegalQ <= 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            RESET: stateNext = T0;
            T0:    stateNext = T1;
            T1:    stateNext = T2;
            T2:    stateNext = T3;
            T3: begin
                if (opClassQ.halt || opClassQ.illegal)
                    stateNext = HALT;
                else if (opClassQ.jr || opClassQ.portIn || opClassQ.portOut || opClassQ.nop)
                    stateNext = T0;
                else
                    stateNext = T4;
            end
            T4:    stateNext = (opClassQ.unary || opClassQ.jal) ? T0 : T5;
            T5:    stateNext = (opClassQ.alu || opClassQ.imm || opClassQ.ldi) ? T0 : T6;
            T6:    stateNext = opClassQ.br ? T0 : T7;
            T7:    stateNext = T0;
            HALT:  stateNext = HALT;
            default: stateNext = RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0;  IncPC = 1'b0;  PCin = 1'b0;  MARin = 1'b0;
        MDRin = 1'b0;  MDRout = 1'b0; IRin = 1'b0;  read = 1'b0;
        write = 1'b0;  RAMenable = 1'b0;
        Gra = 1'b0;    Grb = 1'b0;    Grc = 1'b0;   Rin = 1'b0;  Rout = 1'b0;
        BAout = 1'b0;  CSignout = 1'b0; Yin = 1'b0; conin = 1'b0;
        ZMuxEnbale = 1'b0; ZMuxOut = 1'b0;
        OutPortenable = 1'b0; PortInout = 1'b0; R15inC = 1'b0;
        aluControl = '0;
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (liveClass.alu || liveClass.imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (liveClass.unary) begin
                    Grb = 1'b1; Rout = 1'b1; ZMuxEnbale = 1'b1; aluControl = ir[31:27];
                end else if (liveClass.ld || liveClass.ldi || liveClass.st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (liveClass.br) begin
                    Gra = 1'b1; Rout = 1'b1; conin = 1'b1;
                end else if (liveClass.jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (liveClass.jal) begin
                    PCout = 1'b1; R15inC = 1'b1;
                end else if (liveClass.portIn) begin
                    PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (liveClass.portOut) begin
                    Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1;
                end
            end
            T4: begin
                if (liveClass.alu) begin
                    Grc = 1'b1; Rout = 1'b1; ZMuxEnbale = 1'b1; aluControl = ir[31:27];
                end else if (liveClass.imm) begin
                    CSignout = 1'b1; ZMuxEnbale = 1'b1; aluControl = ir[31:27];
                end else if (liveClass.unary) begin
                    ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (liveClass.ld || liveClass.ldi || liveClass.st) begin
                    CSignout = 1'b1; ZMuxEnbale = 1'b1; aluControl = OP_ADD;
                end else if (liveClass.br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (liveClass.jal) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end
            end
            T5: begin
                if (liveClass.alu || liveClass.imm || liveClass.ldi) begin
                    ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (liveClass.ld || liveClass.st) begin
                    ZMuxOut = 1'b1; MARin = 1'b1;
                end else if (liveClass.br) begin
                    CSignout = 1'b1; ZMuxEnbale = 1'b1; aluControl = OP_ADD;
                end
            end
            T6: begin
                if (liveClass.ld) begin
                    read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1;
                end else if (liveClass.st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (liveClass.br && conOut) begin
                    ZMuxOut = 1'b1; PCin = 1'b1;
                end
            end
            T7: begin
                if (liveClass.ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (liveClass.st) begin
                    write = 1'b1; RAMenable = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ZSelect = 1'b0;
    assign ZLOin   = 1'b0;
    assign ZLOout  = 1'b0;
    assign run     = (state != RESET) && (state != HALT);
    assign illegal = illegalQ;

    assign unusedBits = {ir[26:0], liveClass.nop, liveClass.halt, liveClass.illegal,
                         opClassQ.ld, opClassQ.st};

endmodule

// File: tb/tb_control_unit.sv
// Checks control_unit against a per-opcode microstep table built from the
// instruction descriptions, with randomized instruction streams.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        conOut;
    logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, read, write, RAMenable;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CSignout, Yin, conin, ZMuxEnbale;
    logic ZSelect, ZMuxOut, ZLOin, ZLOout, OutPortenable, PortInout, R15inC;
    logic [4:0] aluControl;
    logic run, illegal;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .conOut(conOut),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .read(read), .write(write), .RAMenable(RAMenable),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CSignout(CSignout), .Yin(Yin), .conin(conin), .ZMuxEnbale(ZMuxEnbale),
        .ZSelect(ZSelect), .ZMuxOut(ZMuxOut), .ZLOin(ZLOin), .ZLOout(ZLOout),
        .OutPortenable(OutPortenable), .PortInout(PortInout), .R15inC(R15inC),
        .aluControl(aluControl), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    localparam logic [26:0] M_PCOUT = 27'd1 << 0,  M_INCPC = 27'd1 << 1,  M_PCIN = 27'd1 << 2;
    localparam logic [26:0] M_MARIN = 27'd1 << 3,  M_MDRIN = 27'd1 << 4,  M_MDROUT = 27'd1 << 5;
    localparam logic [26:0] M_IRIN = 27'd1 << 6,   M_READ = 27'd1 << 7,   M_WRITE = 27'd1 << 8;
    localparam logic [26:0] M_RAM = 27'd1 << 9,    M_GRA = 27'd1 << 10,   M_GRB = 27'd1 << 11;
    localparam logic [26:0] M_GRC = 27'd1 << 12,   M_RIN = 27'd1 << 13,   M_ROUT = 27'd1 << 14;
    localparam logic [26:0] M_BAOUT = 27'd1 << 15, M_CSIGN = 27'd1 << 16, M_YIN = 27'd1 << 17;
    localparam logic [26:0] M_CONIN = 27'd1 << 18, M_ZEN = 27'd1 << 19,   M_ZOUT = 27'd1 << 21;
    localparam logic [26:0] M_OUTP = 27'd1 << 24,  M_PORTIN = 27'd1 << 25, M_R15 = 27'd1 << 26;
    localparam logic [26:0] M_BUS = M_PCOUT | M_MDROUT | M_ROUT | M_ZOUT | M_CSIGN | M_PORTIN;
    localparam logic [26:0] FETCH0 = M_PCOUT | M_MARIN | M_INCPC;

    logic [26:0] obs;
    assign obs = {R15inC, PortInout, OutPortenable, ZLOout, ZLOin, ZMuxOut, ZSelect,
                  ZMuxEnbale, conin, Yin, CSignout, BAout, Rout, Rin, Grc, Grb, Gra,
                  RAMenable, write, read, IRin, MDRout, MDRin, MARin, PCin, IncPC, PCout};

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected microstep table for one instruction: strobe set and ALU code per cycle.
    logic [26:0] expMask [16];
    logic [4:0]  expAlu  [16];
    int          expLen;

    task automatic push(input logic [26:0] m, input logic [4:0] a);
        expMask[expLen] = m;
        expAlu[expLen]  = a;
        expLen++;
    endtask

    task automatic buildExpect(input logic [4:0] op, input logic con);
        expLen = 0;
        push(FETCH0, 5'd0);
        push(M_READ | M_RAM | M_MDRIN, 5'd0);
        push(M_MDROUT | M_IRIN, 5'd0);
        if (op >= 5'd3 && op <= 5'd11) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_GRC | M_ROUT | M_ZEN, op);
            push(M_ZOUT | M_GRA | M_RIN, 5'd0);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            push(M_GRB | M_ROUT | M_YIN, 5'd0);
            push(M_CSIGN | M_ZEN, op);
            push(M_ZOUT | M_GRA | M_RIN, 5'd0);
        end else if (op == 5'd17 || op == 5'd18) begin
            push(M_GRB | M_ROUT | M_ZEN, op);
            push(M_ZOUT | M_GRA | M_RIN, 5'd0);
        end else if (op <= 5'd2) begin
            push(M_GRB | M_BAOUT | M_YIN, 5'd0);
            push(M_CSIGN | M_ZEN, 5'd3);
            if (op == 5'd1) begin
                push(M_ZOUT | M_GRA | M_RIN, 5'd0);
            end else begin
                push(M_ZOUT | M_MARIN, 5'd0);
                if (op == 5'd0) begin
                    push(M_READ | M_RAM | M_MDRIN, 5'd0);
                    push(M_MDROUT | M_GRA | M_RIN, 5'd0);
                end else begin
                    push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                    push(M_WRITE | M_RAM, 5'd0);
                end
            end
        end else if (op == 5'd19) begin
            push(M_GRA | M_ROUT | M_CONIN, 5'd0);
            push(M_PCOUT | M_YIN, 5'd0);
            push(M_CSIGN | M_ZEN, 5'd3);
            push(con ? (M_ZOUT | M_PCIN) : 27'd0, 5'd0);
        end else if (op == 5'd20) begin
            push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (op == 5'd21) begin
            push(M_PCOUT | M_R15, 5'd0);
            push(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (op == 5'd22) begin
            push(M_PORTIN | M_GRA | M_RIN, 5'd0);
        end else if (op == 5'd23) begin
            push(M_GRA | M_ROUT | M_OUTP, 5'd0);
        end else begin
            push(27'd0, 5'd0);   // nop, halt or undefined: one quiet T3
        end
    endtask

    task automatic checkCycle(input string tag, input logic [26:0] m, input logic [4:0] a,
                              input logic expRun, input logic expIll);
        int drivers;
        logic [26:0] busBits;
        checkVal({tag, ".strobes"}, {5'd0, obs}, {5'd0, m});
        checkVal({tag, ".alu"}, {27'd0, aluControl}, {27'd0, a});
        checkVal({tag, ".run"}, {31'd0, run}, {31'd0, expRun});
        checkVal({tag, ".illegal"}, {31'd0, illegal}, {31'd0, expIll});
        busBits = obs & M_BUS;
        drivers = $countones(busBits);
        checkVal({tag, ".busDrivers<=1"}, {31'd0, drivers <= 1}, 32'd1);
    endtask

    // Walks the first n microsteps from a negedge inside T0.
    task automatic runSteps(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkCycle($sformatf("%s.s%0d", tag, i), expMask[i], expAlu[i], 1'b1, 1'b0);
            @(negedge clock);
        end
    endtask

    task automatic runInstr(input string tag, input logic [31:0] irv, input logic con,
                            input int expCycles);
        ir = irv;
        conOut = con;
        buildExpect(irv[31:27], con);
        checkVal({tag, ".cycles"}, expLen, expCycles);
        runSteps(tag, expLen);
        checkCycle({tag, ".backToT0"}, FETCH0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic doReset(input string tag);
        @(negedge clock);
        clear = 1'b1;
        #1;
        checkCycle({tag, ".inReset"}, 27'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        checkCycle({tag, ".firstT0"}, FETCH0, 5'd0, 1'b1, 1'b0);
    endtask

    localparam int NLEGAL = 22;
    logic [4:0] legalOps [NLEGAL] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
                                      5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

    initial begin
        logic [31:0] rnd;
        logic [4:0]  op;
        int          cyc;

        clear = 1'b1;
        ir = '0;
        conOut = 1'b0;
        #12;
        checkCycle("reset", 27'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        checkCycle("firstT0", FETCH0, 5'd0, 1'b1, 1'b0);

        runInstr("add", 32'h1A918000, 1'b0, 6);
        runInstr("ld", 32'h00800000 + 32'h0000_0055, 1'b0, 8);
        runInstr("st", 32'h10800012, 1'b1, 8);
        runInstr("ldi", 32'h08800007, 1'b0, 6);
        runInstr("brTaken", 32'h99800004, 1'b1, 7);
        runInstr("brNotTaken", 32'h99800004, 1'b0, 7);
        runInstr("jal", 32'hA9000000, 1'b0, 5);
        runInstr("jr", 32'hA1000000, 1'b0, 4);
        runInstr("neg", 32'h89100000, 1'b0, 5);
        runInstr("nop", 32'hD0000000, 1'b0, 4);

        for (int k = 0; k < 60; k++) begin
            rnd = $urandom();
            op = legalOps[$urandom_range(0, NLEGAL - 1)];
            ir = {op, rnd[26:0]};
            conOut = 1'($urandom_range(0, 1));
            buildExpect(op, conOut);
            runSteps($sformatf("rnd%0d_op%0d", k, op), expLen);
            checkCycle($sformatf("rnd%0d.backToT0", k), FETCH0, 5'd0, 1'b1, 1'b0);
        end

        // Abort an ld in T5: everything must drop with clear, then refetch.
        ir = 32'h00800010;
        conOut = 1'b0;
        buildExpect(5'd0, 1'b0);
        runSteps("ldAbort", 5);
        checkCycle("ldAbort.T5", expMask[5], expAlu[5], 1'b1, 1'b0);
        clear = 1'b1;
        #1;
        checkCycle("ldAbort.cleared", 27'd0, 5'd0, 1'b0, 1'b0);
        #3;
        clear = 1'b0;
        @(negedge clock);
        checkCycle("ldAbort.refetch", FETCH0, 5'd0, 1'b1, 1'b0);

        ir = {5'b01111, 27'h0};
        buildExpect(5'b01111, 1'b0);
        runSteps("mul", expLen);
        cyc = 0;
        repeat (20) begin
            checkCycle($sformatf("mulHalt%0d", cyc), 27'd0, 5'd0, 1'b0, 1'b1);
            cyc++;
            @(negedge clock);
        end
        ir = 32'h1A918000;
        @(negedge clock);
        checkCycle("mulHaltStill", 27'd0, 5'd0, 1'b0, 1'b1);

        doReset("afterMul");
        ir = {5'b11011, 27'h0};
        buildExpect(5'b11011, 1'b0);
        runSteps("halt", expLen);
        repeat (5) begin
            checkCycle("haltLegal", 27'd0, 5'd0, 1'b0, 1'b0);
            @(negedge clock);
        end

        doReset("final");
        ir = {5'b11100, 27'h0};
        buildExpect(5'b11100, 1'b0);
        runSteps("undef11100", expLen);
        checkCycle("undef11100.halt", 27'd0, 5'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
